data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Load/store controller sitting directly downstream of the multicycle processor's MEM stage.
- Accepts one-cycle MemRead/MemWrite requests with byte address, store data and funct3 size code.
- Drives a word-organised synchronous data RAM with byte strobes and fixed read latency.
- Returns aligned, sign/zero-extended load data with a done pulse, and flags misaligned, out-of-range or conflicting requests.

Parameters:
- ADDR_WIDTH, 9, RAM word-address width (2^ADDR_WIDTH words of 32 bits).
- RAM_LATENCY, 1, cycles from a ram_en cycle to valid ram_rdata (range 1..4).
- BASE_ADDR, 32'h10010000, byte address mapped to RAM word 0.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- MemRead  in  1  load request, sampled only in IDLE.
- MemWrite  in  1  store request, sampled only in IDLE.
- dAddress  in  32  byte address.
- dWriteData  in  32  store data; low byte/halfword used for SB/SH.
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- dReadData  out  32  extended load result.
- mem_done  out  1  one-cycle completion pulse.
- mem_err  out  1  one-cycle error pulse, coincident with mem_done.
- busy  out  1  high in every state except IDLE.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_wstrb  out  4  byte write strobes; bit i covers bits 8i+7:8i.
- ram_rdata  in  32  RAM read data.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. dReadData, mem_done, mem_err, busy, ram_en, ram_we, ram_addr, ram_wdata and ram_wstrb all go to 0. Reset mid-transaction aborts it with no done pulse.
- States: IDLE, ISSUE, WAIT, RESP, ERR.
- IDLE, request at cycle T, addr latched, offset = dAddress - BASE_ADDR:
  - Error if any of the following hold; go to ERR, no RAM activity:
    - MemRead and MemWrite both high.
    - funct3 invalid for the operation (stores accept only 000/001/010).
    - Misaligned: H/HU with offset[0]=1, or W with offset[1:0]≠0.
    - offset ≥ 4·2^ADDR_WIDTH (unsigned compare, covers dAddress < BASE_ADDR).
  - Otherwise go to ISSUE.
- ERR (cycle T+1): mem_done=1, mem_err=1, dReadData unchanged; next state IDLE.
- ISSUE (cycle T+1): ram_en=1, ram_addr=offset[ADDR_WIDTH+1:2].
  - Store: ram_we=1, next state RESP.
    - SW: ram_wstrb=1111, ram_wdata=dWriteData.
    - SH: ram_wdata={2{dWriteData[15:0]}}, ram_wstrb=0011 at offset[1]=0, 1100 at offset[1]=1.
    - SB: ram_wdata={4{dWriteData[7:0]}}, ram_wstrb=1<<offset[1:0].
  - Load: ram_we=0, ram_wstrb=0000, RAM_LATENCY counter loaded, next state WAIT.
- Outside ISSUE, ram_en, ram_we and ram_wstrb are 0.
- WAIT: counter counts down; ram_rdata is captured on the edge ending cycle T+1+RAM_LATENCY, then next state RESP.
- Load extraction from the captured word:
  - Byte select is offset[1:0]; halfword select is offset[1].
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- RESP:
  - Load: cycle T+2+RAM_LATENCY. Store: cycle T+2.
  - mem_done=1 and mem_err=0; for a load, dReadData is updated on the same edge that raises mem_done.
  - Next state IDLE.
- dReadData holds its value until the next successful load completes; stores and errors leave it unchanged.
- Requests asserted while busy=1 are ignored, not queued.
- A new request may be accepted in the cycle after mem_done (back-to-back).
- All outputs are registered.

Test Plan:
- rst low for 3 cycles during a WAIT → all outputs 0 immediately; after release, LW at 0x10010000 completes normally.
- SW 0xDEADBEEF @0x10010004 → cycle T+1: ram_addr=1, wstrb=1111, done at T+2. LW @0x10010004 (latency 1) → ram_en at T+1, dReadData=0xDEADBEEF with done at T+3.
- SB 0x000000A5 @0x10010007 → wdata=0xA5A5A5A5, wstrb=1000. LB @0x10010007 → 0xFFFFFFA5; LBU → 0x000000A5.
- Word 0xA5ADBEEF at word 1: LH @0x10010006 → 0xFFFFA5AD; LHU → 0x0000A5AD; LH @0x10010004 → 0xFFFFBEEF.
- LW @0x10010002, SH @0x10010001, LW @0x10010800, and MemRead+MemWrite together → each gives mem_done=mem_err=1 at T+1, ram_en never high, dReadData unchanged.
- RAM_LATENCY=3: LW done at T+5; a MemRead pulse during busy is ignored; a request in the cycle after done is accepted.

Source files
------------

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_ctrl
// Brief   : MEM-stage load/store controller for a word-wide synchronous RAM.
// Revision: 1.0
// ============================================================================
module data_mem_ctrl #(
    parameter int          ADDR_WIDTH  = 9,
    parameter int          RAM_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h10010000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [31:0]           dAddress,
    input  logic [31:0]           dWriteData,
    input  logic [2:0]            funct3,
    output logic [31:0]           dReadData,
    output logic                  mem_done,
    output logic                  mem_err,
    output logic                  busy,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    output logic [3:0]            ram_wstrb,
    input  logic [31:0]           ram_rdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;
    localparam logic [2:0] c_LAT   = 3'(RAM_LATENCY);

    logic [2:0]  r_state, w_nextState;
    logic [2:0]  r_cnt;
    logic        r_isStore;
    logic [2:0]  r_f3;
    logic [1:0]  r_byteOff;

    logic [31:0] w_offset;
    logic        w_req, w_funcOk, w_misaligned, w_outOfRange, w_reqErr;
    logic [31:0] w_wdata;
    logic [3:0]  w_strbSel;
    logic        w_issueNext, w_doneNext, w_errNext, w_busyNext, w_weNext, w_capture;
    logic [31:0] w_shifted, w_loadData;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_req        = MemRead | MemWrite;
    assign w_offset     = dAddress - BASE_ADDR;
    // Below-base addresses wrap to huge offsets, so one compare covers both ends.
    assign w_outOfRange = |w_offset[31:ADDR_WIDTH+2];
    assign w_misaligned = ((funct3[1:0] == 2'b01) && w_offset[0]) ||
                          ((funct3[1:0] == 2'b10) && (w_offset[1:0] != 2'b00));

    always_comb begin
        w_funcOk = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: w_funcOk = 1'b1;
            3'b100, 3'b101:         w_funcOk = !MemWrite;
            default:                w_funcOk = 1'b0;
        endcase
    end

    assign w_reqErr = (MemRead && MemWrite) || !w_funcOk || w_misaligned || w_outOfRange;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = S_IDLE;
        case (r_state)
            S_IDLE:  w_nextState = !w_req ? S_IDLE : (w_reqErr ? S_ERR : S_ISSUE);
            S_ISSUE: w_nextState = r_isStore ? S_RESP : S_WAIT;
            S_WAIT:  w_nextState = (r_cnt == 3'd1) ? S_RESP : S_WAIT;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        w_wdata   = dWriteData;
        w_strbSel = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                w_wdata   = {4{dWriteData[7:0]}};
                w_strbSel = 4'b0001 << w_offset[1:0];
            end
            2'b01: begin
                w_wdata   = {2{dWriteData[15:0]}};
                w_strbSel = w_offset[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata   = dWriteData;
                w_strbSel = 4'b1111;
            end
        endcase
    end

    always_comb begin
        w_shifted = ram_rdata >> {r_byteOff, 3'b000};
        w_byte    = w_shifted[7:0];
        w_half    = r_byteOff[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (r_f3)
            3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
            3'b100:  w_loadData = {24'd0, w_byte};
            3'b101:  w_loadData = {16'd0, w_half};
            default: w_loadData = ram_rdata;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        w_issueNext = (w_nextState == S_ISSUE);
        w_doneNext  = (w_nextState == S_RESP) || (w_nextState == S_ERR);
        w_errNext   = (w_nextState == S_ERR);
        w_busyNext  = (w_nextState != S_IDLE);
        w_weNext    = w_issueNext && MemWrite;
        w_capture   = (r_state == S_WAIT) && (r_cnt == 3'd1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_isStore <= 1'b0;
            r_f3      <= 3'd0;
            r_byteOff <= 2'd0;
            r_cnt     <= 3'd0;
        end else begin
            if (r_state == S_IDLE && w_req) begin
                r_isStore <= MemWrite;
                r_f3      <= funct3;
                r_byteOff <= w_offset[1:0];
            end
            if (r_state == S_ISSUE)     r_cnt <= c_LAT;
            else if (r_state == S_WAIT) r_cnt <= r_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dReadData <= 32'd0;
            mem_done  <= 1'b0;
            mem_err   <= 1'b0;
            busy      <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= 32'd0;
            ram_wstrb <= 4'd0;
        end else begin
            mem_done  <= w_doneNext;
            mem_err   <= w_errNext;
            busy      <= w_busyNext;
            ram_en    <= w_issueNext;
            ram_we    <= w_weNext;
            ram_wstrb <= w_weNext ? w_strbSel : 4'd0;
            if (w_issueNext) begin
                ram_addr  <= w_offset[ADDR_WIDTH+1:2];
                ram_wdata <= w_wdata;
            end
            if (w_capture) dReadData <= w_loadData;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_ctrl
// Brief   : Randomised and directed bench; instance 0 uses latency 1, instance 1 latency 3.
// Revision: 1.0
// ============================================================================
module tb_data_mem_ctrl;
    localparam logic [31:0] BASE = 32'h10010000;
    localparam int          AW   = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          memRead [2];
    logic          memWrite[2];
    logic [31:0]   dAddr   [2];
    logic [31:0]   dWData  [2];
    logic [2:0]    f3      [2];
    logic [31:0]   dRData  [2];
    logic          memDone [2];
    logic          memErr  [2];
    logic          busyO   [2];
    logic          ramEn   [2];
    logic          ramWe   [2];
    logic [AW-1:0] ramAddr [2];
    logic [31:0]   ramWdata[2];
    logic [3:0]    ramWstrb[2];
    logic [31:0]   ramRdata[2];

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            localparam int LAT = (g == 0) ? 1 : 3;
            logic [31:0] mem [512];
            logic [31:0] pipe[4];
            initial for (int i = 0; i < 512; i++) mem[i] = 32'd0;
            always @(posedge clk) begin
                if (ramEn[g] && ramWe[g])
                    for (int b = 0; b < 4; b++)
                        if (ramWstrb[g][b]) mem[ramAddr[g]][8*b +: 8] <= ramWdata[g][8*b +: 8];
                pipe[0] <= (ramEn[g] && !ramWe[g]) ? mem[ramAddr[g]] : 32'hxxxxxxxx;
                for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
            end
            assign ramRdata[g] = pipe[LAT-1];

            data_mem_ctrl #(.ADDR_WIDTH(AW), .RAM_LATENCY(LAT), .BASE_ADDR(BASE)) u_dut (
                .clk(clk), .rst(rst), .MemRead(memRead[g]), .MemWrite(memWrite[g]),
                .dAddress(dAddr[g]), .dWriteData(dWData[g]), .funct3(f3[g]),
                .dReadData(dRData[g]), .mem_done(memDone[g]), .mem_err(memErr[g]),
                .busy(busyO[g]), .ram_en(ramEn[g]), .ram_we(ramWe[g]), .ram_addr(ramAddr[g]),
                .ram_wdata(ramWdata[g]), .ram_wstrb(ramWstrb[g]), .ram_rdata(ramRdata[g])
            );
        end
    endgenerate

    int            nCmp = 0;
    int            nFail = 0;
    logic [31:0]   refMem[2][512];
    logic [31:0]   refRd [2];
    int            lat   [2] = '{1, 3};

    int            dc;
    bit            er, se, iw;
    logic [AW-1:0] ia;
    logic [31:0]   iwd;
    logic [3:0]    is;

    function automatic bit refErr(bit rd, bit wr, logic [2:0] fn, logic [31:0] a);
        logic [31:0] off = a - BASE;
        if (rd && wr) return 1'b1;
        if (wr && fn > 3'd2) return 1'b1;
        if (rd && !(fn inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if ((fn == 3'd1 || fn == 3'd5) && (off % 2 != 0)) return 1'b1;
        if (fn == 3'd2 && (off % 4 != 0)) return 1'b1;
        if (off >= 32'(4 * 512)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] refLoad(int k, logic [2:0] fn, logic [31:0] a);
        logic [31:0] off = a - BASE;
        logic [31:0] w   = refMem[k][off / 4];
        logic [7:0]  b   = 8'((w >> (8 * (off % 4))) & 32'hFF);
        logic [15:0] h   = 16'((w >> (16 * ((off / 2) % 2))) & 32'hFFFF);
        case (fn)
            3'd0:    return 32'($signed(b));
            3'd1:    return 32'($signed(h));
            3'd4:    return {24'd0, b};
            3'd5:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    task automatic refStore(int k, logic [2:0] fn, logic [31:0] a, logic [31:0] wd);
        logic [31:0] off = a - BASE;
        logic [31:0] mask, val;
        int sh;
        if (fn == 3'd0) begin sh = 8 * (off % 4);        mask = 32'hFF   << sh; val = (wd & 32'hFF)   << sh; end
        else if (fn == 3'd1) begin sh = 16 * ((off / 2) % 2); mask = 32'hFFFF << sh; val = (wd & 32'hFFFF) << sh; end
        else begin mask = 32'hFFFFFFFF; val = wd; end
        refMem[k][off / 4] = (refMem[k][off / 4] & ~mask) | val;
    endtask

    // Drives one request (cycle T) and observes to completion; doneCyc is relative to T, -1 on timeout.
    task automatic run_req(input int k, input bit rd, input bit wr, input logic [2:0] fn,
                           input logic [31:0] a, input logic [31:0] wd, input int pulseCyc,
                           output int doneCyc, output bit err, output bit sawEn,
                           output logic [AW-1:0] iAddr, output logic [31:0] iWdata,
                           output logic [3:0] iStrb, output bit iWe);
        @(posedge clk);
        @(negedge clk);
        memRead[k] = rd; memWrite[k] = wr; f3[k] = fn; dAddr[k] = a; dWData[k] = wd;
        @(posedge clk); #1;
        memRead[k] = 1'b0; memWrite[k] = 1'b0;
        doneCyc = -1; err = 1'b0; sawEn = 1'b0; iAddr = '0; iWdata = '0; iStrb = '0; iWe = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == pulseCyc) begin memRead[k] = 1'b1; dAddr[k] = a ^ 32'h8; end
            else if (c == pulseCyc + 1) memRead[k] = 1'b0;
            if (ramEn[k]) begin
                sawEn = 1'b1; iAddr = ramAddr[k]; iWdata = ramWdata[k]; iStrb = ramWstrb[k]; iWe = ramWe[k];
            end
            if (memDone[k]) begin doneCyc = c; err = memErr[k]; break; end
            @(posedge clk); #1;
        end
        memRead[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            nCmp++;
            if ({dRData[k], memDone[k], memErr[k], busyO[k], ramEn[k], ramWe[k], ramAddr[k], ramWdata[k], ramWstrb[k]} !== '0) begin
                nFail++; $display("FAIL reset_state k=%0d dRData=%h done=%b busy=%b en=%b wstrb=%b want all zero",
                                  k, dRData[k], memDone[k], busyO[k], ramEn[k], ramWstrb[k]);
            end
        end
        // Abort a latency-3 load while it sits in WAIT.
        @(negedge clk);
        memRead[1] = 1'b1; f3[1] = 3'd2; dAddr[1] = BASE;
        @(posedge clk); #1; memRead[1] = 1'b0;
        @(posedge clk); #1;
        nCmp++;
        if (busyO[1] !== 1'b1) begin nFail++; $display("FAIL busy_in_wait got %b want 1", busyO[1]); end
        #2 rst = 1'b0;
        #1;
        nCmp++;
        if ({dRData[1], memDone[1], memErr[1], busyO[1], ramEn[1], ramWe[1], ramAddr[1], ramWdata[1], ramWstrb[1]} !== '0) begin
            nFail++; $display("FAIL async_reset dRData=%h done=%b busy=%b en=%b want all zero",
                              dRData[1], memDone[1], busyO[1], ramEn[1]);
        end
        repeat (3) @(posedge clk);
        #1;
        nCmp++;
        if (memDone[1] !== 1'b0 || busyO[1] !== 1'b0) begin
            nFail++; $display("FAIL held_reset done=%b busy=%b want 0 0", memDone[1], busyO[1]);
        end
        @(negedge clk); rst = 1'b1;
        refRd[0] = 32'd0; refRd[1] = 32'd0;
        run_req(1, 0, 1, 3'd2, BASE, 32'h13579BDF, 0, dc, er, se, ia, iwd, is, iw);
        refStore(1, 3'd2, BASE, 32'h13579BDF);
        run_req(1, 1, 0, 3'd2, BASE, 32'd0, 0, dc, er, se, ia, iwd, is, iw);
        nCmp++;
        if (dc !== 5 || er !== 1'b0 || dRData[1] !== 32'h13579BDF) begin
            nFail++; $display("FAIL post_reset_lw done_cyc=%0d err=%b data=%h want 5 0 13579bdf", dc, er, dRData[1]);
        end
        refRd[1] = 32'h13579BDF;
    endtask

    task automatic test_store_load();
        run_req(0, 0, 1, 3'd2, BASE + 4, 32'hDEADBEEF, 0, dc, er, se, ia, iwd, is, iw);
        refStore(0, 3'd2, BASE + 4, 32'hDEADBEEF);
        nCmp++;
        if (dc !== 2 || er !== 1'b0) begin nFail++; $display("FAIL sw_timing done_cyc=%0d err=%b want 2 0", dc, er); end
        nCmp++;
        if (ia !== 9'd1 || is !== 4'b1111 || iwd !== 32'hDEADBEEF || iw !== 1'b1) begin
            nFail++; $display("FAIL sw_issue addr=%0d strb=%b wdata=%h we=%b want 1 1111 deadbeef 1", ia, is, iwd, iw);
        end
        run_req(0, 1, 0, 3'd2, BASE + 4, 32'd0, 0, dc, er, se, ia, iwd, is, iw);
        nCmp++;
        if (dc !== 3 || se !== 1'b1 || ia !== 9'd1 || dRData[0] !== 32'hDEADBEEF) begin
            nFail++; $display("FAIL lw_lat1 done_cyc=%0d en=%b addr=%0d data=%h want 3 1 1 deadbeef", dc, se, ia, dRData[0]);
        end
        refRd[0] = 32'hDEADBEEF;
    endtask

    task automatic test_byte();
        run_req(0, 0, 1, 3'd0, BASE + 7, 32'h000000A5, 0, dc, er, se, ia, iwd, is, iw);
        refStore(0, 3'd0, BASE + 7, 32'h000000A5);
        nCmp++;
        if (dc !== 2 || iwd !== 32'hA5A5A5A5 || is !== 4'b1000) begin
            nFail++; $display("FAIL sb_issue done_cyc=%0d wdata=%h strb=%b want 2 a5a5a5a5 1000", dc, iwd, is);
        end
        run_req(0, 1, 0, 3'd0, BASE + 7, 32'd0, 0, dc, er, se, ia, iwd, is, iw);
        nCmp++;
        if (dRData[0] !== 32'hFFFFFFA5) begin nFail++; $display("FAIL lb got %h want ffffffa5", dRData[0]); end
        run_req(0, 1, 0, 3'd4, BASE + 7, 32'd0, 0, dc, er, se, ia, iwd, is, iw);
        nCmp++;
        if (dRData[0] !== 32'h000000A5) begin nFail++; $display("FAIL lbu got %h want 000000a5", dRData[0]); end
        refRd[0] = 32'h000000A5;
    endtask

    task automatic test_half();
        logic [31:0] addrs[3] = '{BASE + 6, BASE + 6, BASE + 4};
        logic [2:0]  fns  [3] = '{3'd1, 3'd5, 3'd1};
        logic [31:0] exps [3] = '{32'hFFFFA5AD, 32'h0000A5AD, 32'hFFFFBEEF};
        for (int i = 0; i < 3; i++) begin
            run_req(0, 1, 0, fns[i], addrs[i], 32'd0, 0, dc, er, se, ia, iwd, is, iw);
            nCmp++;
            if (dRData[0] !== exps[i] || er !== 1'b0) begin
                nFail++; $display("FAIL half_load%0d got %h err=%b want %h 0", i, dRData[0], er, exps[i]);
            end
        end
        refRd[0] = 32'hFFFFBEEF;
    endtask

    task automatic test_errors();
        bit          rds[4] = '{1, 0, 1, 1};
        bit          wrs[4] = '{0, 1, 0, 1};
        logic [2:0]  fns[4] = '{3'd2, 3'd1, 3'd2, 3'd2};
        logic [31:0] ads[4] = '{BASE + 2, BASE + 1, BASE + 32'h800, BASE + 4};
        for (int i = 0; i < 4; i++) begin
            run_req(0, rds[i], wrs[i], fns[i], ads[i], 32'h12345678, 0, dc, er, se, ia, iwd, is, iw);
            nCmp++;
            if (dc !== 1 || er !== 1'b1 || se !== 1'b0) begin
                nFail++; $display("FAIL err_case%0d done_cyc=%0d err=%b ram_en_seen=%b want 1 1 0", i, dc, er, se);
            end
            nCmp++;
            if (dRData[0] !== refRd[0]) begin
                nFail++; $display("FAIL err_case%0d_data got %h want %h", i, dRData[0], refRd[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_req(1, 0, 1, 3'd2, BASE + 8, 32'h0BADF00D, 0, dc, er, se, ia, iwd, is, iw);
        refStore(1, 3'd2, BASE + 8, 32'h0BADF00D);
        run_req(1, 1, 0, 3'd2, BASE + 8, 32'd0, 2, dc, er, se, ia, iwd, is, iw);
        nCmp++;
        if (dc !== 5 || dRData[1] !== 32'h0BADF00D) begin
            nFail++; $display("FAIL lw_lat3_busy_pulse done_cyc=%0d data=%h want 5 0badf00d", dc, dRData[1]);
        end
        run_req(1, 1, 0, 3'd5, BASE + 8, 32'd0, 0, dc, er, se, ia, iwd, is, iw);
        nCmp++;
        if (dc !== 5 || dRData[1] !== 32'h0000F00D) begin
            nFail++; $display("FAIL b2b_lhu done_cyc=%0d data=%h want 5 0000f00d", dc, dRData[1]);
        end
        refRd[1] = 32'h0000F00D;
    endtask

    task automatic test_random();
        bit rd, wr, eErr;
        logic [2:0]  fn;
        logic [31:0] a, wd;
        int r, eDc;
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 80; n++) begin
                r = $urandom_range(0, 15);
                if (r == 0)      a = BASE + 32'h800 + $urandom_range(0, 15);
                else if (r == 1) a = BASE - $urandom_range(1, 8);
                else             a = BASE + $urandom_range(0, 63);
                fn = 3'($urandom_range(0, 7));
                wd = $urandom;
                r  = $urandom_range(0, 9);
                rd = (r == 0) || (r > 4);
                wr = (r <= 4);
                eErr = refErr(rd, wr, fn, a);
                eDc  = eErr ? 1 : (wr ? 2 : 2 + lat[k]);
                run_req(k, rd, wr, fn, a, wd, 0, dc, er, se, ia, iwd, is, iw);
                if (!eErr && wr) refStore(k, fn, a, wd);
                if (!eErr && rd) refRd[k] = refLoad(k, fn, a);
                nCmp++;
                if (dc !== eDc || er !== eErr || dRData[k] !== refRd[k]) begin
                    nFail++; $display("FAIL rand k=%0d n=%0d rd=%b wr=%b f3=%0d addr=%h: cyc=%0d err=%b data=%h want %0d %b %h",
                                      k, n, rd, wr, fn, a, dc, er, dRData[k], eDc, eErr, refRd[k]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            memRead[k] = 1'b0; memWrite[k] = 1'b0; dAddr[k] = '0; dWData[k] = '0; f3[k] = '0; refRd[k] = '0;
            for (int i = 0; i < 512; i++) refMem[k][i] = 32'd0;
        end
        test_reset();
        test_store_load();
        test_byte();
        test_half();
        test_errors();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
`default_nettype wire
